// File: rtl/bus_responder.sv
// Bus-segment responder: decodes an aligned window holding control registers, sampled status,
// a write counter, a one-shot strobe and write-1-to-clear sticky events. Reads return at a fixed latency.
module bus_responder #(
  parameter int unsigned   AW     = 24,
  parameter int unsigned   DW     = 32,
  parameter int unsigned   NREG   = 8,
  parameter logic [AW-1:0] BASE   = 24'h000100,
  parameter int unsigned   RD_LAT = 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [AW-1:0]        addr,
  input  logic [DW-1:0]        wdata,
  input  logic                 wstb,
  output logic [DW-1:0]        rdata,
  output logic [NREG*DW-1:0]   ctrl,
  output logic [DW-1:0]        stb_out,
  input  logic [DW-1:0]        status_in,
  input  logic [DW-1:0]        ev_in
);

  localparam int unsigned LW = $clog2(2 * NREG);

  logic [DW-1:0] status_q;
  logic [DW-1:0] wcount;
  logic [DW-1:0] sticky;
  logic [DW-1:0] rd_pipe [RD_LAT];

  logic          hit_c;
  logic [LW-1:0] off_c;
  logic          acc_c;
  logic          wr_wcnt_c;
  logic          wr_stb_c;
  logic [DW-1:0] clr_c;
  logic [DW-1:0] rd_mux_c;

  // Address decode and write qualification
  always_comb begin
    hit_c     = (addr[AW-1:LW] == BASE[AW-1:LW]);
    off_c     = addr[LW-1:0];
    acc_c     = wstb && hit_c && (off_c <= LW'(NREG + 3));
    wr_wcnt_c = wstb && hit_c && (off_c == LW'(NREG + 1));
    wr_stb_c  = wstb && hit_c && (off_c == LW'(NREG + 2));
    clr_c     = (wstb && hit_c && (off_c == LW'(NREG + 3))) ? wdata : '0;
  end

  // Read mux over pre-edge state; strobe, reserved and miss read as zero
  always_comb begin
    rd_mux_c = '0;
    if (hit_c) begin
      for (int unsigned k = 0; k < NREG; k++) begin
        if (off_c == LW'(k)) rd_mux_c = ctrl[k*DW +: DW];
      end
      if (off_c == LW'(NREG))          rd_mux_c = status_q;
      else if (off_c == LW'(NREG + 1)) rd_mux_c = wcount;
      else if (off_c == LW'(NREG + 3)) rd_mux_c = sticky;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ctrl     <= '0;
      stb_out  <= '0;
      status_q <= '0;
      wcount   <= '0;
      sticky   <= '0;
      for (int unsigned i = 0; i < RD_LAT; i++) rd_pipe[i] <= '0;
    end else begin
      for (int unsigned k = 0; k < NREG; k++) begin
        if (wstb && hit_c && off_c == LW'(k)) ctrl[k*DW +: DW] <= wdata;
      end
      status_q <= status_in;
      // A clear of the counter wins over counting the clearing write itself
      if (wr_wcnt_c)  wcount <= '0;
      else if (acc_c) wcount <= wcount + DW'(1);
      stb_out  <= wr_stb_c ? wdata : '0;
      sticky   <= (sticky & ~clr_c) | ev_in;
      rd_pipe[0] <= rd_mux_c;
      for (int unsigned i = 1; i < RD_LAT; i++) rd_pipe[i] <= rd_pipe[i-1];
    end
  end

  assign rdata = rd_pipe[RD_LAT-1];

endmodule

// File: tb/tb_bus_responder.sv
// Scoreboard bench for bus_responder: stimulus queues expected outputs with a due cycle,
// a negedge monitor compares them. A second instance runs with RD_LAT=3.
module tb_bus_responder;
  localparam int unsigned AW = 24;
  localparam int unsigned DW = 32;
  localparam int unsigned NREG = 8;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic               rst_n, wstb;
  logic [AW-1:0]      addr;
  logic [DW-1:0]      wdata, rdata, stb_out, status_in, ev_in;
  logic [NREG*DW-1:0] ctrl;

  logic               rst3_n, wstb3;
  logic [AW-1:0]      addr3;
  logic [DW-1:0]      wdata3, rdata3, stb3, status3, ev3;
  logic [NREG*DW-1:0] ctrl3;

  bus_responder #(.AW(AW), .DW(DW), .NREG(NREG), .BASE(24'h000100), .RD_LAT(1)) dut (
    .clk(clk), .rst_n(rst_n), .addr(addr), .wdata(wdata), .wstb(wstb), .rdata(rdata),
    .ctrl(ctrl), .stb_out(stb_out), .status_in(status_in), .ev_in(ev_in));

  bus_responder #(.AW(AW), .DW(DW), .NREG(NREG), .BASE(24'h000100), .RD_LAT(3)) dut3 (
    .clk(clk), .rst_n(rst3_n), .addr(addr3), .wdata(wdata3), .wstb(wstb3), .rdata(rdata3),
    .ctrl(ctrl3), .stb_out(stb3), .status_in(status3), .ev_in(ev3));

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  typedef struct {
    int unsigned due;
    int          kind;
    int          k;
    logic [31:0] exp;
    string       name;
  } exp_t;
  exp_t sb[$];

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at cycle %0d", name, got, exp, cyc);
    end
  endtask

  function automatic logic [31:0] actual(input int kind, input int k);
    case (kind)
      0:       return rdata;
      1:       return stb_out;
      2:       return ctrl[k*32 +: 32];
      default: return rdata3;
    endcase
  endfunction

  task automatic push(input int kind, input int k, input logic [31:0] exp, input string name,
                      input int unsigned lat);
    exp_t e;
    e.due = cyc + lat; e.kind = kind; e.k = k; e.exp = exp; e.name = name;
    sb.push_back(e);
  endtask

  // Monitor: compare every entry whose due cycle has arrived
  always @(negedge clk) begin
    for (int i = sb.size() - 1; i >= 0; i--) begin
      if (sb[i].due <= cyc) begin
        if (sb[i].due != cyc) chk({sb[i].name, "_late"}, 32'd1, 32'd0);
        else chk(sb[i].name, actual(sb[i].kind, sb[i].k), sb[i].exp);
        sb.delete(i);
      end
    end
  end

  task automatic drv(input logic [23:0] a, input logic [31:0] d, input logic w, input logic [31:0] e);
    addr = a; wdata = d; wstb = w; ev_in = e;
    @(negedge clk);
  endtask

  task automatic rd(input logic [23:0] a, input logic [31:0] exp, input string name);
    push(0, 0, exp, name, 1);
    drv(a, 32'h0, 1'b0, 32'h0);
  endtask

  task automatic drv3(input logic [23:0] a, input logic [31:0] d, input logic w);
    addr3 = a; wdata3 = d; wstb3 = w; ev3 = '0;
    @(negedge clk);
  endtask

  task automatic rd3(input logic [23:0] a, input logic [31:0] exp, input string name);
    push(3, 0, exp, name, 3);
    drv3(a, 32'h0, 1'b0);
  endtask

  logic [31:0] sweep_exp [12];

  initial begin
    rst_n = 1'b0; addr = '0; wdata = '0; wstb = 1'b0; ev_in = '0; status_in = 32'hCAFE0001;
    rst3_n = 1'b0; addr3 = '0; wdata3 = '0; wstb3 = 1'b0; ev3 = '0; status3 = 32'h000055AA;
    repeat (2) @(negedge clk);
    chk("rst_rdata", rdata, 32'h0);
    chk("rst_stb", stb_out, 32'h0);
    chk("rst_ctrl_or", {31'h0, |ctrl}, 32'h0);
    rst_n = 1'b1; rst3_n = 1'b1;
    @(negedge clk);

    // ctrl write and read-back
    push(2, 3, 32'hDEADBEEF, "ctrl3_wr", 1);
    push(2, 0, 32'h0, "ctrl0_untouched", 1);
    drv(24'h103, 32'hDEADBEEF, 1'b1, 32'h0);
    rd(24'h103, 32'hDEADBEEF, "rd_ctrl3");
    rd(24'h109, 32'h1, "wcount_1");
    // read during write returns the old value
    push(0, 0, 32'hDEADBEEF, "rd_during_wr_old", 1);
    drv(24'h103, 32'h11111111, 1'b1, 32'h0);
    rd(24'h103, 32'h11111111, "rd_ctrl3_new");

    // miss and reserved writes are ignored and uncounted
    push(0, 0, 32'h0, "rd_miss_during_wr", 1);
    drv(24'h200, 32'h12345678, 1'b1, 32'h0);
    push(0, 0, 32'h0, "rd_rsvd_during_wr", 1);
    drv(24'h10C, 32'h12345678, 1'b1, 32'h0);
    rd(24'h200, 32'h0, "rd_miss");
    push(2, 4, 32'h0, "ctrl4_after_rsvd", 1);
    push(2, 3, 32'h11111111, "ctrl3_after_miss", 1);
    rd(24'h10C, 32'h0, "rd_rsvd");
    rd(24'h109, 32'h2, "wcount_2");

    // status: sampled each cycle, writes counted but ignored
    rd(24'h108, 32'hCAFE0001, "status_rd");
    drv(24'h108, 32'hFFFFFFFF, 1'b1, 32'h0);
    status_in = 32'h0BADF00D;
    rd(24'h108, 32'hCAFE0001, "status_old_sample");
    rd(24'h108, 32'h0BADF00D, "status_new_sample");
    rd(24'h109, 32'h3, "wcount_3");

    // strobe pulses
    push(1, 0, 32'h5, "stb_pulse5", 1);
    drv(24'h10A, 32'h5, 1'b1, 32'h0);
    push(1, 0, 32'h0, "stb_clear", 1);
    rd(24'h10A, 32'h0, "rd_strobe_zero");
    push(1, 0, 32'hA, "stb_b2b_a", 1);
    drv(24'h10A, 32'hA, 1'b1, 32'h0);
    push(1, 0, 32'hB, "stb_b2b_b", 1);
    drv(24'h10A, 32'hB, 1'b1, 32'h0);
    push(1, 0, 32'h0, "stb_b2b_clear", 1);
    drv(24'h000, 32'h0, 1'b0, 32'h0);

    // sticky events
    drv(24'h000, 32'h0, 1'b0, 32'h3);
    rd(24'h10B, 32'h3, "sticky_set");
    drv(24'h10B, 32'h1, 1'b1, 32'h1);
    rd(24'h10B, 32'h3, "sticky_set_wins");
    drv(24'h10B, 32'h3, 1'b1, 32'h0);
    rd(24'h10B, 32'h0, "sticky_cleared");
    drv(24'h10B, 32'h4, 1'b1, 32'h4);
    push(0, 0, 32'h4, "sticky_held", 1);
    drv(24'h10B, 32'h0, 1'b0, 32'h4);
    rd(24'h10B, 32'h4, "sticky_after_held");
    rd(24'h109, 32'h9, "wcount_9");

    // wcount wrap and clear priority
    force dut.wcount = 32'hFFFFFFFE;
    drv(24'h000, 32'h0, 1'b0, 32'h0);
    release dut.wcount;
    rd(24'h109, 32'hFFFFFFFE, "wcount_preload");
    drv(24'h100, 32'h1, 1'b1, 32'h0);
    drv(24'h101, 32'h2, 1'b1, 32'h0);
    rd(24'h109, 32'h0, "wcount_wrap");
    drv(24'h109, 32'h0, 1'b1, 32'h0);
    rd(24'h109, 32'h0, "wcount_clear_not_counted");
    drv(24'h000, 32'h0, 1'b0, 32'h0);

    // RD_LAT=3 instance: load ctrl, then sweep reads back-to-back
    for (int k = 0; k < 8; k++) drv3(24'h100 + 24'(k), 32'h10000000 + 32'(k), 1'b1);
    sweep_exp = '{32'h10000000, 32'h10000001, 32'h10000002, 32'h10000003,
                  32'h10000004, 32'h10000005, 32'h10000006, 32'h10000007,
                  32'h000055AA, 32'h00000008, 32'h00000000, 32'h00000000};
    for (int i = 0; i < 12; i++) rd3(24'h100 + 24'(i), sweep_exp[i], $sformatf("lat3_sweep_%0d", i));
    repeat (4) drv3(24'h100, 32'h0, 1'b0);
    chk("lat3_rdata_before_rst", rdata3, 32'h10000000);

    // Half-cycle reset during a write
    addr3 = 24'h102; wdata3 = 32'hFFFFFFFF; wstb3 = 1'b1;
    #2 rst3_n = 1'b0;
    #1;
    chk("rst3_rdata_immediate", rdata3, 32'h0);
    chk("rst3_ctrl0_immediate", ctrl3[31:0], 32'h0);
    chk("rst3_stb_immediate", stb3, 32'h0);
    #4 rst3_n = 1'b1;
    wstb3 = 1'b0;
    @(negedge clk);
    chk("rst3_ctrl2_write_lost", ctrl3[95:64], 32'h0);
    rd3(24'h102, 32'h0, "rst3_rd_ctrl2");
    rd3(24'h109, 32'h0, "rst3_rd_wcount");
    rd3(24'h100, 32'h0, "rst3_rd_ctrl0");
    repeat (5) drv3(24'h000, 32'h0, 1'b0);

    while (sb.size() != 0) begin
      chk({sb[0].name, "_never_checked"}, 32'd1, 32'd0);
      void'(sb.pop_front());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/bus_responder.md
Name: bus_responder

Overview:
- Peripheral-side responder for the single-clock host bus (addr/wdata/rdata/wstb, no read strobe).
- Terminates the downstream end of a bus segment and decodes an aligned address window.
- Provides NREG read/write control registers, a sampled status word, a write counter, a self-clearing strobe register and a write-1-to-clear sticky event register.
- Read data returns through a fixed-latency pipeline so the host sees a deterministic read latency.

Parameters:
- AW, 24, bus address width.
- DW, 32, bus data width.
- NREG, 8, number of control registers; power of 2, >=4.
- BASE, 24'h000100, window base; aligned to 2*NREG.
- RD_LAT, 1, read latency in cycles; legal range 1..3.

Ports:
- clk  input  1  bus clock; all logic in this domain.
- rst_n  input  1  asynchronous, active-low reset.
- addr  input  AW  bus address.
- wdata  input  DW  write data.
- wstb  input  1  write strobe, one cycle per write.
- rdata  output  DW  read data for addr presented RD_LAT cycles earlier.
- ctrl  output  NREG*DW  control registers; reg k occupies bits [k*DW +: DW].
- stb_out  output  DW  one-cycle pulses.
- status_in  input  DW  status word, already synchronous to clk.
- ev_in  input  DW  event pulses that set sticky flags.

Behaviour:
- Reset: one clock, clk. Reset is asynchronous and active-low (rst_n). Assertion immediately clears:
  - all ctrl registers, stb_out, rdata and the read pipeline to 0;
  - the write counter, the sticky register and the status sample to 0.
- Reset mid-write discards that write. The first rising edge after deassertion operates normally.
- Decode:
  - hit = (addr[AW-1:log2(2*NREG)] == BASE[AW-1:log2(2*NREG)]); off = addr[log2(2*NREG)-1:0].
  - Offsets 0..NREG-1: ctrl. NREG: status. NREG+1: wcount. NREG+2: strobe. NREG+3: sticky. NREG+4..2*NREG-1: reserved.
  - Reserved and miss addresses read 0; writes to them are ignored and are not counted.
- ctrl writes: on a clk edge with wstb&hit&off<NREG, ctrl[off] <= wdata. ctrl is visible on the ctrl port the next cycle.
- status: status_q <= status_in every cycle. Reads return status_q. Writes are ignored but counted.
- wcount (DW bits):
  - Increments on every accepted write (hit, offset 0..NREG+3) and wraps from all-ones to 0.
  - A write to offset NREG+1 clears it to 0. The clear has priority, and the clearing write itself is not counted.
- strobe:
  - A write at NREG+2 drives stb_out <= wdata for exactly one cycle; stb_out is 0 on all other cycles.
  - Back-to-back writes give consecutive pulses.
  - Reads of this offset return 0.
- sticky:
  - Next value = (sticky & ~clr) | ev_in, where clr = wdata when writing offset NREG+3, else 0.
  - On a bit, a simultaneous set and clear leaves it set.
  - ev_in held high keeps the bit set.
- Read path:
  - Stage 1 registers mux(off, hit) from the pre-edge register state, so a read issued in the same cycle as a write to that address returns the old value.
  - Stages 2..RD_LAT are pure delay registers.
  - rdata updates every cycle whether or not wstb is asserted.
- No backpressure. Every cycle carries a valid address, and every wstb cycle is a complete write.
- Arithmetic: only wcount+1, which uses DW-bit modulo arithmetic. No other width changes.

Test Plan:
- Defaults NREG=8, BASE=0x100, RD_LAT=1 unless stated. Map: ctrl 0x100-0x107, status 0x108, wcount 0x109, strobe 0x10A, sticky 0x10B, reserved 0x10C-0x10F.
- Write 0xDEADBEEF to 0x103, then hold addr=0x103 with no wstb -> ctrl[3]=0xDEADBEEF one cycle later; rdata=0xDEADBEEF one cycle after addr is held; other ctrl stay 0; wcount reads 1.
- Write 0x12345678 to 0x200 and 0x10C, then read both -> rdata=0 for each; ctrl unchanged; wcount unchanged.
- Write 0x00000005 to 0x10A -> stb_out=0x00000005 for exactly one cycle, then 0; a read of 0x10A returns 0.
- Pulse ev_in=0x3 for one cycle -> sticky reads 0x3. Then write 0x1 to 0x10B in the same cycle that ev_in=0x1 -> sticky stays 0x3. A later write of 0x3 with ev_in=0 -> sticky reads 0.
- Preload wcount to 0xFFFFFFFE via 0xFFFFFFFE accepted writes (forced through a bench hook), then make 2 writes -> wcount reads 0. Next, write to 0x109 -> wcount reads 0, not 1.
- RD_LAT=3: sweep addresses 0x100..0x10B back-to-back with reads -> each rdata appears exactly 3 cycles after its address. Assert rst_n low for half a cycle during a write -> all outputs 0 immediately and the write is lost.
